// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing controller with its ALU decoder.
// Optional performance counters are built when MC_PERF_COUNTERS_EN is defined.

module alu_decoder (
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       op5,
   output logic [3:0] alu_control
);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         2'b00: alu_control = ALU_ADD;
         2'b01: alu_control = ALU_SUB;
         default: begin
            case (funct3)
               // instr[30] is an immediate bit for addi, so only R-type subtracts
               3'b000:  alu_control = (funct7_5 & op5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               default: alu_control = ALU_AND;
            endcase
         end
      endcase
   end

endmodule

// state    | meaning
// FETCH    | read instruction at PC, PC <= PC + 4
// DECODE   | read registers, branch target into ALU-out
// MEMADR   | compute load/store address
// MEMREAD  | read data memory at ALU-out
// MEMWB    | write loaded data to register file
// MEMWRITE | write store data to memory
// EXEC_R   | register-register ALU operation
// EXEC_I   | register-immediate ALU operation
// ALUWB    | write ALU-out to register file
// JAL      | PC <= jump target, link = old PC + 4
// BRANCH   | compare rs1/rs2, conditionally load branch target
module multicycle_controller #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 funct7_5,
   input  logic                 zero,
   output logic                 pc_wr_en,
   output logic                 adr_src,
   output logic                 mem_wr_en,
   output logic                 ir_wr_en,
   output logic                 reg_wr_en,
   output logic [1:0]           result_src,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [2:0]           imm_src,
   output logic [3:0]           alu_control,
   output logic                 instr_done,
   output logic                 illegal_instr,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instret_count
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXEC_R   = 4'd6,
      S_EXEC_I   = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10
   } state_t;

   state_t     state;
   state_t     state_next;
   state_t     out_state;
   logic       pc_update;
   logic       branch;
   logic       take;
   logic       ir_raw;
   logic       mem_wr_raw;
   logic       reg_wr_raw;
   logic       done_raw;
   logic       illegal_raw;
   logic [1:0] alu_op;

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH: state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_R:              state_next = S_EXEC_R;
               OP_I:              state_next = S_EXEC_I;
               OP_JAL:            state_next = S_JAL;
               OP_BRANCH:         state_next = S_BRANCH;
               default:           state_next = S_FETCH;
            endcase
         end
         S_MEMADR:   state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_next = S_MEMWB;
         S_EXEC_R:   state_next = S_ALUWB;
         S_EXEC_I:   state_next = S_ALUWB;
         S_JAL:      state_next = S_ALUWB;
         default:    state_next = S_FETCH;
      endcase
   end

   // Selects show FETCH decode during reset; enables are masked below.
   assign out_state = rst ? S_FETCH : state;

   always_comb begin
      pc_update   = 1'b0;
      branch      = 1'b0;
      adr_src     = 1'b0;
      mem_wr_raw  = 1'b0;
      ir_raw      = 1'b0;
      reg_wr_raw  = 1'b0;
      done_raw    = 1'b0;
      illegal_raw = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      case (out_state)
         S_FETCH: begin
            ir_raw     = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_update  = 1'b1;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (opcode)
               OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BRANCH: illegal_raw = 1'b0;
               default: illegal_raw = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_wr_raw = 1'b1;
            done_raw   = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src    = 1'b1;
            mem_wr_raw = 1'b1;
            done_raw   = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_wr_raw = 1'b1;
            done_raw   = 1'b1;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
            done_raw  = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  take = zero;
         3'b001:  take = ~zero;
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      case (opcode)
         OP_STORE:  imm_src = 3'b001;
         OP_BRANCH: imm_src = 3'b010;
         OP_JAL:    imm_src = 3'b011;
         default:   imm_src = 3'b000;
      endcase
   end

   assign pc_wr_en      = (pc_update | (branch & take)) & ~rst;
   assign mem_wr_en     = mem_wr_raw & ~rst;
   assign ir_wr_en      = ir_raw & ~rst;
   assign reg_wr_en     = reg_wr_raw & ~rst;
   assign instr_done    = done_raw & ~rst;
   assign illegal_instr = illegal_raw & ~rst;

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .op5         (opcode[5]),
      .alu_control (alu_control)
   );

`ifdef MC_PERF_COUNTERS_EN
   logic [CNT_WIDTH-1:0] cycle_q;
   logic [CNT_WIDTH-1:0] instret_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q <= cycle_q + 1'b1;
         if (instr_done) instret_q <= instret_q + 1'b1;
      end
   end

   assign cycle_count   = cycle_q;
   assign instret_count = instret_q;
`else
   assign cycle_count   = '0;
   assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control vectors for each
// instruction class, reset abandonment, and the counter outputs.

module tb_multicycle_controller;

`ifdef MC_PERF_COUNTERS_EN
   localparam int CNT_W = 4;
`else
   localparam int CNT_W = 32;
`endif

   localparam logic [3:0] A_ADD = 4'b0000;
   localparam logic [3:0] A_SUB = 4'b0001;
   localparam logic [3:0] A_OR  = 4'b0011;
   localparam logic [3:0] A_SRA = 4'b1001;

   logic             clk = 1'b0;
   logic             rst;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             funct7_5;
   logic             zero;
   logic             pc_wr_en;
   logic             adr_src;
   logic             mem_wr_en;
   logic             ir_wr_en;
   logic             reg_wr_en;
   logic [1:0]       result_src;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [2:0]       imm_src;
   logic [3:0]       alu_control;
   logic             instr_done;
   logic             illegal_instr;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] instret_count;

   int n_checks = 0;
   int n_errors = 0;
   logic [19:0] exp_v [0:7];
   logic [19:0] obs;

   always #5 clk = ~clk;

   multicycle_controller #(.CNT_WIDTH(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .funct3        (funct3),
      .funct7_5      (funct7_5),
      .zero          (zero),
      .pc_wr_en      (pc_wr_en),
      .adr_src       (adr_src),
      .mem_wr_en     (mem_wr_en),
      .ir_wr_en      (ir_wr_en),
      .reg_wr_en     (reg_wr_en),
      .result_src    (result_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .imm_src       (imm_src),
      .alu_control   (alu_control),
      .instr_done    (instr_done),
      .illegal_instr (illegal_instr),
      .cycle_count   (cycle_count),
      .instret_count (instret_count)
   );

   assign obs = {pc_wr_en, adr_src, mem_wr_en, ir_wr_en, reg_wr_en, result_src,
                 alu_src_a, alu_src_b, imm_src, alu_control, instr_done, illegal_instr};

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // {pc_wr, adr, mem_wr, ir_wr, reg_wr, result_src, a, b, imm_src, alu_control, done, illegal}
   function automatic logic [19:0] ctl(input logic pc, input logic adr, input logic mw,
                                       input logic ir, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic done, input logic ill);
      return {pc, adr, mw, ir, rw, rs, a, b, imm, alu, done, ill};
   endfunction

   task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
      opcode   = op;
      funct3   = f3;
      funct7_5 = f7;
      zero     = z;
   endtask

   // Entered one time unit after the edge that starts FETCH; leaves at the next FETCH.
   task automatic run_instr(input string name, input int n);
      #1;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         check($sformatf("%s_c%0d", name, i + 1), {12'b0, obs}, {12'b0, exp_v[i]});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_vec", {12'b0, obs}, {12'b0, ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0)});
      rst = 1'b0;

      // lw
      exp_v[0] = ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0);
      exp_v[1] = ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,A_ADD,0,0);
      exp_v[2] = ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,A_ADD,0,0);
      exp_v[3] = ctl(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,A_ADD,0,0);
      exp_v[4] = ctl(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,A_ADD,1,0);
      run_instr("lw", 5);

      // sw
      set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
      exp_v[0] = ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b001,A_ADD,0,0);
      exp_v[1] = ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b001,A_ADD,0,0);
      exp_v[2] = ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,A_ADD,0,0);
      exp_v[3] = ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b001,A_ADD,1,0);
      run_instr("sw", 4);

      // beq taken
      set_in(7'b1100011, 3'b000, 1'b0, 1'b1);
      exp_v[0] = ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b010,A_ADD,0,0);
      exp_v[1] = ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b010,A_ADD,0,0);
      exp_v[2] = ctl(1,0,0,0,0,2'b00,2'b10,2'b00,3'b010,A_SUB,1,0);
      run_instr("beq_t", 3);

      // beq not taken
      set_in(7'b1100011, 3'b000, 1'b0, 1'b0);
      exp_v[2] = ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,A_SUB,1,0);
      run_instr("beq_nt", 3);

      // bne taken
      set_in(7'b1100011, 3'b001, 1'b0, 1'b0);
      exp_v[2] = ctl(1,0,0,0,0,2'b00,2'b10,2'b00,3'b010,A_SUB,1,0);
      run_instr("bne_t", 3);

      // bne not taken
      set_in(7'b1100011, 3'b001, 1'b0, 1'b1);
      exp_v[2] = ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,A_SUB,1,0);
      run_instr("bne_nt", 3);

      // blt-class funct3 never taken
      set_in(7'b1100011, 3'b100, 1'b0, 1'b1);
      exp_v[2] = ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,A_SUB,1,0);
      run_instr("br_f3_4", 3);

      // sub
      set_in(7'b0110011, 3'b000, 1'b1, 1'b0);
      exp_v[0] = ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0);
      exp_v[1] = ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,A_ADD,0,0);
      exp_v[2] = ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,A_SUB,0,0);
      exp_v[3] = ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,A_ADD,1,0);
      run_instr("sub", 4);

      // or
      set_in(7'b0110011, 3'b110, 1'b0, 1'b0);
      exp_v[2] = ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,A_OR,0,0);
      run_instr("or", 4);

      // addi with instr[30] set must still add
      set_in(7'b0010011, 3'b000, 1'b1, 1'b0);
      exp_v[2] = ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,A_ADD,0,0);
      run_instr("addi", 4);

      // srai
      set_in(7'b0010011, 3'b101, 1'b1, 1'b0);
      exp_v[2] = ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,A_SRA,0,0);
      run_instr("srai", 4);

      // jal
      set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
      exp_v[0] = ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b011,A_ADD,0,0);
      exp_v[1] = ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b011,A_ADD,0,0);
      exp_v[2] = ctl(1,0,0,0,0,2'b00,2'b01,2'b10,3'b011,A_ADD,0,0);
      exp_v[3] = ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b011,A_ADD,1,0);
      run_instr("jal", 4);

      // illegal opcode
      set_in(7'b1111111, 3'b000, 1'b0, 1'b0);
      exp_v[0] = ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0);
      exp_v[1] = ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,A_ADD,0,1);
      run_instr("illegal", 2);

      // lw abandoned by reset during MEMREAD; the FETCH check in the next run
      // also confirms the illegal opcode returned to FETCH
      set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
      exp_v[0] = ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0);
      exp_v[1] = ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,A_ADD,0,0);
      exp_v[2] = ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,A_ADD,0,0);
      run_instr("lw_rst", 3);
      check("lw_rst_memread", {12'b0, obs}, {12'b0, ctl(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,A_ADD,0,0)});
      rst = 1'b1;
      #1;
      check("rst_mid_vec", {12'b0, obs}, {12'b0, ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0)});
      @(posedge clk);
      #1;
      check("rst_mid_regwr", {31'b0, reg_wr_en}, 32'd0);
      check("rst_mid_vec2", {12'b0, obs}, {12'b0, ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0)});
      rst = 1'b0;
      exp_v[0] = ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,A_ADD,0,0);
      exp_v[1] = ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,A_ADD,0,0);
      run_instr("after_rst", 2);

      // counters over 20 cycles of back-to-back R-type
      rst = 1'b1;
      set_in(7'b0110011, 3'b000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("cyc_start", 32'(cycle_count), 32'd0);
      check("ret_start", 32'(instret_count), 32'd0);
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
`ifdef MC_PERF_COUNTERS_EN
         if (i == 15) check("cyc_15", 32'(cycle_count), 32'd15);
         if (i == 16) check("cyc_wrap", 32'(cycle_count), 32'd0);
         if (i == 20) begin
            check("cyc_20", 32'(cycle_count), 32'd4);
            check("ret_20", 32'(instret_count), 32'd5);
         end
`else
         if (i == 20) begin
            check("cyc_off", 32'(cycle_count), 32'd0);
            check("ret_off", 32'(instret_count), 32'd0);
         end
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
